apb_master_arbiter: RTL and testbench

Two-requester APB master front-end for the AHB2APB bridge subsystem. It lets the bridge write/read path (requester 0) and a configuration/DMA agent (requester 1) share one APB bus to up to NSEL slaves. Grants are round-robin, and the block runs the APB IDLE→SETUP→ACCESS sequence with PREADY wait states. Each requester gets a one-cycle completion pulse carrying read data and error status.

---
 rtl/apb_master_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master front-end.
// Requester 0 is the bridge read/write path and requester 1 is the config/DMA agent.
// The FSM runs IDLE -> SETUP -> ACCESS and honours PREADY wait states.
// Each requester gets a one-cycle done pulse that carries err and rdata.
// Optional feature: define APB_ARB_TIMEOUT_EN to end an ACCESS phase after
// TIMEOUT cycles without pready. That completion reports err=1 and rdata=0.
module apb_master_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSEL    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic            req0,
  input  logic            req1,
  input  logic            wr0,
  input  logic            wr1,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW-1:0]   wdata1,
  input  logic [NSEL-1:0] sel0,
  input  logic [NSEL-1:0] sel1,
  output logic            done0,
  output logic            done1,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic [NSEL-1:0] psel,
  output logic            penable,
  output logic            pwrite,
  output logic [AW-1:0]   paddr,
  output logic [DW-1:0]   pwdata,
  input  logic            pready,
  input  logic            pslverr,
  input  logic [DW-1:0]   prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;     // 1 = requester 1 was granted most recently
  logic            cur_q, cur_d;       // requester owning the current transfer
  logic [NSEL-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;

  logic            elig0, elig1;
  logic            gnt, gnt_id, fin;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0]   cnt_q, cnt_d;
`else
  logic            unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Next-state logic: arbitration, APB phase sequencing and completion reporting
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cur_d     = cur_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    gnt       = 1'b0;
    gnt_id    = 1'b0;
    fin       = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    // A requester whose done is high still shows its old req, so mask it.
    elig0 = req0 & ~done0_q;
    elig1 = req1 & ~done1_q;

    unique case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt    = 1'b1;
          gnt_id = (elig0 & elig1) ? ~last_q : elig1;
        end
      end
      SETUP: begin
        if (psel_q == '0) begin
          // No slave is selected, so skip the bus and report an error.
          fin     = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          penable_d = 1'b1;
          state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ACCESS: begin
        if (pready) begin
          fin   = 1'b1;
          err_d = pslverr;
          if (!pwrite_q) rdata_d = prdata;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (fin) begin
          // Only the other requester can be granted on a completion edge.
          if (cur_q ? elig0 : elig1) begin
            gnt    = 1'b1;
            gnt_id = ~cur_q;
          end else begin
            state_d   = IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      done0_d = ~cur_q;
      done1_d = cur_q;
    end

    if (gnt) begin
      state_d   = SETUP;
      cur_d     = gnt_id;
      last_d    = gnt_id;
      penable_d = 1'b0;
      psel_d    = gnt_id ? sel1   : sel0;
      paddr_d   = gnt_id ? addr1  : addr0;
      pwdata_d  = gnt_id ? wdata1 : wdata0;
      pwrite_d  = gnt_id ? wr1    : wr0;
    end
  end

  // State and registered outputs; reset drops the APB bus immediately
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cur_q     <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign done0   = done0_q;
  assign done1   = done1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter.
// Directed scenarios run first, then a randomized phase.
// The reference model is transaction-timestamp based: each grant records its
// owner, payload, slave response and the cycle its done is due.
`timescale 1ns/1ps
module tb_apb_master_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NSEL = 3;
  localparam int TO   = 16;
  localparam int INF  = 1000000;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [1:0]      rq, wr;
  logic [AW-1:0]   ad [2];
  logic [DW-1:0]   wd [2];
  logic [NSEL-1:0] sl [2];
  logic            done0, done1, err, penable, pwrite, pready, pslverr;
  logic [DW-1:0]   rdata, pwdata, prdata;
  logic [NSEL-1:0] psel;
  logic [AW-1:0]   paddr;

  apb_master_arbiter #(.AW(AW), .DW(DW), .NSEL(NSEL), .TIMEOUT(TO)) dut (
    .hclk(hclk), .hreset(hreset),
    .req0(rq[0]), .req1(rq[1]), .wr0(wr[0]), .wr1(wr[1]),
    .addr0(ad[0]), .addr1(ad[1]), .wdata0(wd[0]), .wdata1(wd[1]),
    .sel0(sl[0]), .sel1(sl[1]),
    .done0(done0), .done1(done1), .err(err), .rdata(rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 hclk = ~hclk;

  int n_vec, n_err, cyc, base, pen_n, obs_done_n;
  int obs_done_cyc [2];

  // reference model state
  bit              act, nore;
  int              owner, g, done_at, last, p_w;
  logic [NSEL-1:0] p_sel;
  logic [AW-1:0]   p_addr;
  logic [DW-1:0]   p_wd, r_rd, rd_model;
  logic            p_wr, r_err;
  logic [1:0]      prev_done, d_exp;
  int              fw [2];
  int              ferr [2];
  bit              frd_en [2];
  logic [DW-1:0]   frd [2];
  bit              stale [2];
  bit              noise, rnd_req;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    act = 0; nore = 0; last = 1; prev_done = '0; rd_model = '0;
    stale[0] = 0; stale[1] = 0;
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NSEL-1:0] s);
    wr[i] = w; ad[i] = a; wd[i] = d; sl[i] = s; rq[i] = 1'b1;
  endtask

  task automatic rand_issue(input int i);
    logic [NSEL-1:0] s;
    s = NSEL'(1) << $urandom_range(0, NSEL-1);
    if ($urandom_range(0, 7) == 0) s = '0;
    issue(i, 1'($urandom), $urandom, $urandom, s);
  endtask

  task automatic do_grant(input int gid);
    act = 1; owner = gid; last = gid; g = cyc; nore = 0;
    p_sel = sl[gid]; p_addr = ad[gid]; p_wd = wd[gid]; p_wr = wr[gid];
    p_w   = (fw[gid] >= 0) ? fw[gid] : int'($urandom_range(0, 4));
    r_err = (ferr[gid] >= 0) ? (ferr[gid] != 0) : 1'($urandom);
    r_rd  = frd_en[gid] ? frd[gid] : $urandom;
    if (p_sel == '0) begin
      done_at = g + 1; nore = 1;
    end else if (p_w >= INF) begin
`ifdef APB_ARB_TIMEOUT_EN
      done_at = g + 1 + TO;
`else
      done_at = g + INF;
`endif
    end else begin
      done_at = g + 2 + p_w;
    end
  endtask

  // One clock: update the model for this edge, compare, then drive next inputs.
  task automatic cycle();
    bit   e0, e1, gnt;
    int   gid;
    logic err_exp;
    @(posedge hclk); #1;
    cyc++;
    d_exp = '0; gnt = 0; gid = 0; err_exp = 1'b0;
    if (done0) obs_done_cyc[0] = cyc;
    if (done1) obs_done_cyc[1] = cyc;
    if (done0 | done1) obs_done_n++;
    if (penable) pen_n++;

    if (act && cyc == done_at) begin
      d_exp[owner] = 1'b1;
      if (p_sel == '0) err_exp = 1'b1;
      else if (p_w >= INF) begin err_exp = 1'b1; rd_model = '0; end
      else begin
        err_exp = r_err;
        if (!p_wr) rd_model = r_rd;
      end
      act = 0;
      if (!nore && rq[1-owner] && !prev_done[1-owner]) begin gnt = 1; gid = 1 - owner; end
    end else if (!act) begin
      e0 = rq[0] && !prev_done[0];
      e1 = rq[1] && !prev_done[1];
      if (e0 || e1) begin
        gnt = 1;
        gid = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
      end
    end
    if (gnt) do_grant(gid);

    chk("done0", done0, d_exp[0]);
    chk("done1", done1, d_exp[1]);
    if (act) begin
      chk("psel", psel, p_sel);
      chk("penable", penable, cyc > g);
      chk("paddr", paddr, p_addr);
      chk("pwdata", pwdata, p_wd);
      chk("pwrite", pwrite, p_wr);
    end else begin
      chk("psel_idle", psel, 0);
      chk("penable_idle", penable, 0);
    end
    if (d_exp != 0) begin
      chk("err", err, err_exp);
      chk("rdata", rdata, rd_model);
    end
    prev_done = d_exp;

    // slave response for this cycle
    if (act && p_sel != '0 && p_w < INF && cyc == g + 1 + p_w) begin
      pready = 1'b1; pslverr = r_err; prdata = r_rd;
    end else if (act && cyc > g) begin
      pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
    end else begin
      pready = noise ? 1'($urandom) : 1'b0; pslverr = 1'($urandom); prdata = $urandom;
    end

    // requesters
    for (int i = 0; i < 2; i++) begin
      if (d_exp[i]) begin
        if (rnd_req && $urandom_range(0, 1) == 1) stale[i] = 1;
        else rq[i] = 1'b0;
      end else if (stale[i]) begin
        rq[i] = 1'b0; stale[i] = 0;
      end else if (rnd_req && !rq[i] && $urandom_range(0, 2) == 0) begin
        rand_issue(i);
      end
    end
  endtask

  task automatic apply_reset();
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    hreset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; pen_n = 0; obs_done_n = 0;
    obs_done_cyc[0] = -1; obs_done_cyc[1] = -1;
    rq = '0; wr = '0; pready = 0; pslverr = 0; prdata = '0;
    for (int i = 0; i < 2; i++) begin
      ad[i] = '0; wd[i] = '0; sl[i] = '0; fw[i] = -1; ferr[i] = -1; frd_en[i] = 0; frd[i] = '0;
    end
    noise = 0; rnd_req = 0;
    model_reset();
    @(posedge hclk); #1;
    apply_reset();

    // single zero-wait read on requester 0
    fw[0] = 0; ferr[0] = 0; frd_en[0] = 1; frd[0] = 32'hA5A5_0001;
    issue(0, 1'b0, 32'h10, 32'h0, 3'b001);
    cycle(); chk("t1_psel", psel, 3'b001); chk("t1_pen_setup", penable, 0);
    cycle(); chk("t1_pen_access", penable, 1);
    cycle(); chk("t1_done0", done0, 1); chk("t1_rdata", rdata, 32'hA5A5_0001); chk("t1_err", err, 0);
    repeat (2) cycle();
    frd_en[0] = 0;

    // simultaneous writes from reset: requester 0 first, then requester 1 back-to-back
    apply_reset();
    fw[0] = 0; fw[1] = 0; ferr[0] = 0; ferr[1] = 0;
    base = cyc;
    issue(0, 1'b1, 32'h100, 32'h1111_1111, 3'b001);
    issue(1, 1'b1, 32'h200, 32'h2222_2222, 3'b010);
    cycle(); chk("t2_pwdata0", pwdata, 32'h1111_1111);
    cycle();
    cycle(); chk("t2_pwdata1", pwdata, 32'h2222_2222); chk("t2_psel1", psel, 3'b010);
    repeat (3) cycle();
    chk("t2_done0_cyc", obs_done_cyc[0] - base, 3);
    chk("t2_gap", obs_done_cyc[1] - obs_done_cyc[0], 2);

    // three wait states and slave error on a requester-1 write
    fw[1] = 3; ferr[1] = 1;
    base = pen_n;
    issue(1, 1'b1, 32'h300, 32'h3333_3333, 3'b100);
    repeat (7) cycle();
    chk("t3_pen_cycles", pen_n - base, 4);

    // reset asserted during ACCESS, then requester 1 re-arbitrates
    fw[1] = 6; ferr[1] = 0;
    issue(1, 1'b0, 32'h400, 32'h0, 3'b010);
    repeat (3) cycle();
    hreset = 1'b1; #1;
    chk("t4_psel", psel, 0); chk("t4_penable", penable, 0); chk("t4_paddr", paddr, 0);
    chk("t4_done1", done1, 0);
    repeat (2) @(posedge hclk);
    #1;
    fw[1] = 0;
    hreset = 1'b0;
    model_reset();
    base = cyc;
    repeat (4) cycle();
    chk("t4_done1_cyc", obs_done_cyc[1] - base, 3);

    // randomized traffic with pready noise and stale request cycles
    fw[0] = -1; fw[1] = -1; ferr[0] = -1; ferr[1] = -1;
    noise = 1; rnd_req = 1;
    repeat (400) cycle();
    rnd_req = 0;
    repeat (40) cycle();
    noise = 0;

    // slave never ready, requester 1 waiting behind
    fw[0] = INF; fw[1] = 0; ferr[1] = 0;
    base = cyc;
    issue(0, 1'b0, 32'h500, 32'h0, 3'b001);
    cycle();
    issue(1, 1'b1, 32'h600, 32'h66, 3'b010);
`ifdef APB_ARB_TIMEOUT_EN
    repeat (TO + 6) cycle();
    chk("t5_done0_cyc", obs_done_cyc[0] - base, TO + 2);
    chk("t5_done1_cyc", obs_done_cyc[1] - base, TO + 4);
`else
    obs_done_n = 0;
    repeat (100) cycle();
    chk("t5_no_done", obs_done_n, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
